// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: run/pause/single-step sequencer plus RAW hazard stall and EX forwarding selects
// for a 5-stage pipeline; drives the stage enables and the ID/EX bubble.
module pipe_hazard_ctrl #(
  parameter int RA_W     = 4,
  parameter int FWD_EN   = 1,
  parameter int RF_WT    = 0,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pause_i,
  input  logic             step_pulse_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic             id_rs_used_i,
  input  logic             id_rt_used_i,
  input  logic [RA_W-1:0]  ex_wa_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic [RA_W-1:0]  mem_wa_i,
  input  logic             mem_regwrite_i,
  input  logic [RA_W-1:0]  wb_wa_i,
  input  logic             wb_regwrite_i,
  input  logic [RA_W-1:0]  ex_rs_i,
  input  logic [RA_W-1:0]  ex_rt_i,
  output logic             adv_o,
  output logic             pc_en_o,
  output logic             idex_bubble_o,
  output logic             stall_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [1:0]       run_state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
  state_t           state_q, state_d;
  logic             run_s1_q, run_s_q, pause_s;
  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q;
  logic             load_use, rs_hit, rt_hit;

  function automatic logic m(input logic [RA_W-1:0] r, input logic [RA_W-1:0] wa, input logic we);
    return we && (r == wa) && !(ZERO_REG != 0 && r == '0);
  endfunction

  function automatic logic any_hit(input logic [RA_W-1:0] r, input logic [RA_W-1:0] ewa,
                                   input logic ewe, input logic [RA_W-1:0] mwa, input logic mwe,
                                   input logic [RA_W-1:0] wwa, input logic wwe);
    return m(r, ewa, ewe) || m(r, mwa, mwe) || (RF_WT == 0 && m(r, wwa, wwe));
  endfunction

  function automatic logic [1:0] fsel(input logic [RA_W-1:0] r, input logic [RA_W-1:0] mwa,
                                      input logic mwe, input logic [RA_W-1:0] wwa, input logic wwe);
    return FWD_EN == 0 ? 2'd0 : m(r, mwa, mwe) ? 2'd1 : m(r, wwa, wwe) ? 2'd2 : 2'd0;
  endfunction

  // The synchroniser carries "not paused", so its zero reset value reads as paused until
  // the real switch level has crossed both flops.
  assign pause_s = ~run_s_q;

  assign load_use = ex_memread_i & ex_regwrite_i &
                    ((id_rs_used_i & m(id_rs_i, ex_wa_i, 1'b1)) | (id_rt_used_i & m(id_rt_i, ex_wa_i, 1'b1)));
  assign rs_hit   = id_rs_used_i & any_hit(id_rs_i, ex_wa_i, ex_regwrite_i, mem_wa_i, mem_regwrite_i,
                                           wb_wa_i, wb_regwrite_i);
  assign rt_hit   = id_rt_used_i & any_hit(id_rt_i, ex_wa_i, ex_regwrite_i, mem_wa_i, mem_regwrite_i,
                                           wb_wa_i, wb_regwrite_i);
  assign stall_o  = FWD_EN != 0 ? load_use : (rs_hit | rt_hit);
  assign fwd_a_o  = fsel(ex_rs_i, mem_wa_i, mem_regwrite_i, wb_wa_i, wb_regwrite_i);
  assign fwd_b_o  = fsel(ex_rt_i, mem_wa_i, mem_regwrite_i, wb_wa_i, wb_regwrite_i);

  assign adv_o         = (state_q == RUN) || (state_q == STEP);
  assign pc_en_o       = adv_o & ~stall_o;
  assign idex_bubble_o = adv_o & stall_o;
  assign run_state_o   = state_q;
  assign cycle_cnt_o   = cycle_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;

  always_comb begin
    state_d = state_q == HALT ? (!pause_s ? RUN : step_pulse_i ? STEP : HALT) :
              state_q == RUN  ? (pause_s ? HALT : RUN) : HALT;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_s1_q    <= 1'b0;
      run_s_q     <= 1'b0;
      state_q     <= HALT;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      run_s1_q <= ~pause_i;
      run_s_q  <= run_s1_q;
      state_q  <= state_d;
      if (adv_o) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (adv_o && stall_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven hazard/forwarding vectors plus hand-written run/step/stall sequences
// on three configurations (forwarding, no-forward, no-forward with write-through).
module tb_pipe_hazard_ctrl;
  typedef struct {
    int rs, rt, ru, tu, exw, exr, exm, mw, mr, ww, wr, xrs, xrt, s_f, s_n, s_w, fa, fb;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, pause = 1'b1, step = 1'b0;
  logic [3:0] id_rs, id_rt, ex_wa, mem_wa, wb_wa, ex_rs, ex_rt;
  logic id_rs_used, id_rt_used, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic adv [3], pc_en [3], bub [3], stl [3];
  logic [1:0] fa [3], fb [3], rst_st [3];
  logic [3:0] f_cc, f_sc;
  logic [15:0] n_cc, n_sc, w_cc, w_sc;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl [12];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(1), .RF_WT(0), .ZERO_REG(1), .CNT_W(4)) u_f (
    .clk_i(clk), .rst_n_i(rst_n), .pause_i(pause), .step_pulse_i(step),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
    .ex_wa_i(ex_wa), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
    .mem_wa_i(mem_wa), .mem_regwrite_i(mem_regwrite), .wb_wa_i(wb_wa), .wb_regwrite_i(wb_regwrite),
    .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .adv_o(adv[0]), .pc_en_o(pc_en[0]), .idex_bubble_o(bub[0]),
    .stall_o(stl[0]), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]), .run_state_o(rst_st[0]),
    .cycle_cnt_o(f_cc), .stall_cnt_o(f_sc));

  pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(0), .RF_WT(0), .ZERO_REG(0), .CNT_W(16)) u_n (
    .clk_i(clk), .rst_n_i(rst_n), .pause_i(pause), .step_pulse_i(step),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
    .ex_wa_i(ex_wa), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
    .mem_wa_i(mem_wa), .mem_regwrite_i(mem_regwrite), .wb_wa_i(wb_wa), .wb_regwrite_i(wb_regwrite),
    .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .adv_o(adv[1]), .pc_en_o(pc_en[1]), .idex_bubble_o(bub[1]),
    .stall_o(stl[1]), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]), .run_state_o(rst_st[1]),
    .cycle_cnt_o(n_cc), .stall_cnt_o(n_sc));

  pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(0), .RF_WT(1), .ZERO_REG(0), .CNT_W(16)) u_w (
    .clk_i(clk), .rst_n_i(rst_n), .pause_i(pause), .step_pulse_i(step),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
    .ex_wa_i(ex_wa), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
    .mem_wa_i(mem_wa), .mem_regwrite_i(mem_regwrite), .wb_wa_i(wb_wa), .wb_regwrite_i(wb_regwrite),
    .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .adv_o(adv[2]), .pc_en_o(pc_en[2]), .idex_bubble_o(bub[2]),
    .stall_o(stl[2]), .fwd_a_o(fa[2]), .fwd_b_o(fb[2]), .run_state_o(rst_st[2]),
    .cycle_cnt_o(w_cc), .stall_cnt_o(w_sc));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    {id_rs, id_rt, ex_wa, mem_wa, wb_wa, ex_rs, ex_rt} = '0;
    {id_rs_used, id_rt_used, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite} = '0;
  endtask

  task automatic do_reset(input logic p);
    @(negedge clk);
    rst_n = 1'b0;
    clr();
    pause = p;
    step = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 10 && rst_st[0] != 2'd1; i++) @(negedge clk);
    chk("run_entry", int'(rst_st[0]), 1);
  endtask

  task automatic apply(input vec_t v);
    id_rs = 4'(v.rs); id_rt = 4'(v.rt); id_rs_used = v.ru[0]; id_rt_used = v.tu[0];
    ex_wa = 4'(v.exw); ex_regwrite = v.exr[0]; ex_memread = v.exm[0];
    mem_wa = 4'(v.mw); mem_regwrite = v.mr[0]; wb_wa = 4'(v.ww); wb_regwrite = v.wr[0];
    ex_rs = 4'(v.xrs); ex_rt = 4'(v.xrt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_adv;
    //          rs rt ru tu exw exr exm mw mr ww wr xrs xrt s_f s_n s_w fa fb
    tbl[0]  = '{1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0, 0, 0, 0, 0};
    tbl[1]  = '{3, 4, 1, 1, 3, 1, 1, 0, 0, 0, 0, 7, 8,  1, 1, 1, 0, 0};
    tbl[2]  = '{3, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 7, 8,  0, 1, 1, 0, 0};
    tbl[3]  = '{3, 4, 0, 1, 3, 1, 1, 0, 0, 0, 0, 7, 8,  0, 0, 0, 0, 0};
    tbl[4]  = '{1, 3, 1, 1, 3, 1, 1, 0, 0, 0, 0, 7, 8,  1, 1, 1, 0, 0};
    tbl[5]  = '{5, 4, 1, 0, 0, 0, 0, 5, 1, 0, 0, 5, 6,  0, 1, 1, 1, 0};
    tbl[6]  = '{6, 4, 1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 6,  0, 1, 0, 0, 2};
    tbl[7]  = '{9, 10, 1, 1, 0, 0, 0, 5, 1, 5, 1, 5, 5, 0, 0, 0, 1, 1};
    tbl[8]  = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0,  0, 1, 1, 0, 0};
    tbl[9]  = '{5, 5, 1, 1, 5, 0, 1, 5, 0, 5, 0, 5, 5,  0, 0, 0, 0, 0};
    tbl[10] = '{1, 2, 1, 1, 0, 0, 0, 9, 0, 9, 1, 9, 12, 0, 0, 0, 2, 0};
    tbl[11] = '{4, 6, 1, 1, 0, 0, 0, 4, 1, 6, 1, 6, 4,  0, 1, 1, 2, 1};
    clr();

    // reset release with pause low: two synchroniser cycles, RUN after the third edge
    do_reset(1'b0);
    #1;
    chk("rst_state", int'(rst_st[0]), 0);
    chk("rst_adv", int'(adv[0]), 0);
    chk("rst_pc_en", int'(pc_en[0]), 0);
    chk("rst_bubble", int'(bub[0]), 0);
    chk("rst_cycle_cnt", int'(f_cc), 0);
    chk("rst_stall_cnt", int'(n_sc), 0);
    @(posedge clk); #1 chk("t1_edge1_state", int'(rst_st[0]), 0);
    @(posedge clk); #1 chk("t1_edge2_state", int'(rst_st[0]), 0);
    @(posedge clk); #1 chk("t1_edge3_state", int'(rst_st[0]), 1);
    chk("t1_adv", int'(adv[0]), 1);

    // load-use: lw r3 in ID/EX, add r3 in IF/ID
    @(negedge clk);
    ex_wa = 4'd3; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs = 4'd3; id_rs_used = 1'b1;
    #1;
    chk("t3_stall", int'(stl[0]), 1);
    chk("t3_pc_en", int'(pc_en[0]), 0);
    chk("t3_bubble", int'(bub[0]), 1);
    @(negedge clk);
    ex_wa = 4'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_wa = 4'd3; mem_regwrite = 1'b1;
    #1;
    chk("t3_stall_next", int'(stl[0]), 0);
    chk("t3_pc_en_next", int'(pc_en[0]), 1);
    chk("t3_stall_cnt", int'(f_sc), 1);
    @(negedge clk);
    mem_regwrite = 1'b0; wb_wa = 4'd3; wb_regwrite = 1'b1; ex_rs = 4'd3; id_rs_used = 1'b0;
    #1 chk("t3_fwd_a_wb", int'(fa[0]), 2);

    // no-forward dependent ALU pair: EX, MEM, WB matches (write-through drops the WB one)
    do_reset(1'b0);
    wait_run();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clr();
      id_rs = 4'd2; id_rs_used = 1'b1; ex_wa = 4'd2; mem_wa = 4'd2; wb_wa = 4'd2;
      ex_regwrite = (k == 0); mem_regwrite = (k == 1); wb_regwrite = (k == 2);
      #1;
      chk($sformatf("t5_stall_nofwd_c%0d", k), int'(stl[1]), (k < 3) ? 1 : 0);
      chk($sformatf("t5_stall_wt_c%0d", k), int'(stl[2]), (k < 2) ? 1 : 0);
    end
    @(negedge clk);
    chk("t5_stall_cnt_nofwd", int'(n_sc), 3);
    chk("t5_stall_cnt_wt", int'(w_sc), 2);
    chk("t5_stall_cnt_fwd", int'(f_sc), 0);

    // 20 stalled cycles on a 4-bit counter: stall saturates, cycle wraps
    do_reset(1'b0);
    ex_wa = 4'd3; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs = 4'd3; id_rs_used = 1'b1;
    wait_run();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_stall_cnt_sat", int'(f_sc), 15);
    chk("t6_cycle_cnt_wrap", int'(f_cc), 4);
    chk("t6_stall_cnt_wide", int'(n_sc), 20);
    chk("t6_cycle_cnt_wide", int'(n_cc), 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cycle_cnt", int'(f_cc), 0);
    chk("t6_rst_stall_cnt", int'(f_sc), 0);
    chk("t6_rst_state", int'(rst_st[0]), 0);
    chk("t6_rst_adv", int'(adv[0]), 0);
    chk("t6_rst_bubble", int'(bub[0]), 0);

    // combinational hazard/forwarding table, held in HALT
    do_reset(1'b1);
    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall_fwd", i), int'(stl[0]), tbl[i].s_f);
      chk($sformatf("v%0d_stall_nofwd", i), int'(stl[1]), tbl[i].s_n);
      chk($sformatf("v%0d_stall_wt", i), int'(stl[2]), tbl[i].s_w);
      chk($sformatf("v%0d_fwd_a", i), int'(fa[0]), tbl[i].fa);
      chk($sformatf("v%0d_fwd_b", i), int'(fb[0]), tbl[i].fb);
      chk($sformatf("v%0d_fwd_off", i), int'({fa[1], fb[1], fa[2], fb[2]}), 0);
      chk($sformatf("v%0d_halt_bubble", i), int'({bub[0], bub[1], bub[2]}), 0);
    end

    // single-step: three spaced pulses, then one pulse held for two cycles
    clr();
    n_adv = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_adv += int'(adv[0]);
      step = (i % 4 == 0) && (i < 12);
    end
    chk("t2_adv_cycles", n_adv, 3);
    chk("t2_cycle_cnt", int'(f_cc), 3);
    chk("t2_cycle_cnt_wide", int'(n_cc), 3);
    chk("t2_state_halt", int'(rst_st[0]), 0);
    n_adv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_adv += int'(adv[0]);
      step = (i < 2);
    end
    chk("t2_held_pulse_adv", n_adv, 1);
    chk("t2_held_cycle_cnt", int'(f_cc), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
